// File: rtl/decode_rr_arbiter_if.sv
// Request/grant bundle between 32 requesters and the decode_rr_arbiter.
// Requesters use the master modport and the arbiter uses the slave modport.
interface decode_rr_arbiter_if #(
  parameter int N     = 32,
  parameter int IDX_W = 5
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/decode_rr_arbiter.sv
// 32-way round-robin arbiter; the one-hot grant is the registered decode of the owner index.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD cycles of tenure.
module decode_rr_arbiter #(
  parameter int N        = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  decode_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             gnt_valid_r;
  logic [N-1:0]     gnt_r;
  logic             timeout_r;

  logic [IDX_W-1:0] start_s;
  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] win_s;
  logic             found_s;
  logic             force_s;
  logic             release_s;

  function automatic logic [N-1:0] decode_idx(input logic [IDX_W-1:0] idx);
    decode_idx = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold_cnt_r;

  // Tenure limit reached with no voluntary release this cycle
  always_comb begin
    force_s = 1'b0;
    if (state_r == GRANT && !bus.done && hold_cnt_r == 16'(MAX_HOLD - 1)) begin
      force_s = 1'b1;
    end else begin
      force_s = 1'b0;
    end
  end
`else
  assign force_s = 1'b0;
`endif

  assign release_s = (state_r == GRANT) && (bus.done || force_s);

  // Rotating priority search; a releasing owner drops to lowest priority
  always_comb begin
    start_s = ptr_r;
    cand_s  = '0;
    win_s   = '0;
    found_s = 1'b0;
    if (state_r == GRANT) begin
      start_s = gnt_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      start_s = ptr_r;
    end
    for (int i = 0; i < N; i++) begin
      cand_s = start_s + IDX_W'(i);
      if (!found_s && bus.req[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      gnt_idx_r   <= '0;
      gnt_valid_r <= 1'b0;
      gnt_r       <= '0;
      timeout_r   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_r  <= 16'd0;
`endif
    end else begin
      timeout_r <= force_s;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt_idx_r   <= win_s;
            gnt_valid_r <= 1'b1;
            gnt_r       <= decode_idx(win_s);
            state_r     <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_r  <= 16'd0;
`endif
          end
        end
        GRANT: begin
          if (release_s) begin
            ptr_r <= gnt_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            if (found_s) begin
              gnt_idx_r  <= win_s;
              gnt_r      <= decode_idx(win_s);
`ifdef ARB_TIMEOUT_EN
              hold_cnt_r <= 16'd0;
`endif
            end else begin
              gnt_valid_r <= 1'b0;
              gnt_r       <= '0;
              state_r     <= IDLE;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt_r <= hold_cnt_r + 16'd1;
`endif
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_valid_r <= 1'b0;
          gnt_r       <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_decode_rr_arbiter.sv
// Directed bench for decode_rr_arbiter; covers the ARB_TIMEOUT_EN build when that macro is defined.
module tb_decode_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  logic seen_timeout;

  decode_rr_arbiter_if #(.N(32), .IDX_W(5)) bus ();

  decode_rr_arbiter #(.N(32), .IDX_W(5), .MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = 32'h0000_0000;
    bus.done = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_gnt", bus.gnt, 32'h0000_0000);
    chk("rst_valid", {31'd0, bus.gnt_valid}, 32'd0);
    chk("rst_idx", {27'd0, bus.gnt_idx}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);

    // single request, then drop req without done
    bus.req = 32'h0000_0001;
    step();
    chk("first_gnt", bus.gnt, 32'h0000_0001);
    chk("first_idx", {27'd0, bus.gnt_idx}, 32'd0);
    chk("first_valid", {31'd0, bus.gnt_valid}, 32'd1);
    bus.req = 32'h0000_0000;
    repeat (12) step();
    chk("hold_gnt", bus.gnt, 32'h0000_0001);
    chk("hold_valid", {31'd0, bus.gnt_valid}, 32'd1);
    bus.done = 1'b1;
    step();
    chk("rel_idle_valid", {31'd0, bus.gnt_valid}, 32'd0);
    chk("rel_idle_gnt", bus.gnt, 32'h0000_0000);
    chk("rel_idle_idx_hold", {27'd0, bus.gnt_idx}, 32'd0);
    bus.done = 1'b0;

    // all requesting, done every cycle: full rotation
    rst     = 1'b1;
    bus.req = 32'hFFFF_FFFF;
    step();
    rst = 1'b0;
    chk("rr_rst_valid", {31'd0, bus.gnt_valid}, 32'd0);
    step();
    chk("rr_idx_0", {27'd0, bus.gnt_idx}, 32'd0);
    bus.done = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk($sformatf("rr_idx_%0d", i), {27'd0, bus.gnt_idx}, 32'(i % 32));
      chk($sformatf("rr_gnt_%0d", i), bus.gnt, 32'h0000_0001 << (i % 32));
      chk($sformatf("rr_valid_%0d", i), {31'd0, bus.gnt_valid}, 32'd1);
    end

    // wrap between the two ends; owner is 0 here
    bus.req = 32'h8000_0001;
    step();
    chk("wrap_31", {27'd0, bus.gnt_idx}, 32'd31);
    chk("wrap_31_gnt", bus.gnt, 32'h8000_0000);
    step();
    chk("wrap_0", {27'd0, bus.gnt_idx}, 32'd0);
    bus.req = 32'h0000_0000;
    step();
    chk("wrap_idle_valid", {31'd0, bus.gnt_valid}, 32'd0);
    chk("wrap_idle_gnt", bus.gnt, 32'h0000_0000);
    // done in IDLE is ignored
    step();
    chk("idle_done_valid", {31'd0, bus.gnt_valid}, 32'd0);
    bus.done = 1'b0;

    // reset in the middle of a grant to 5
    bus.req = 32'h0000_0020;
    step();
    chk("g5_idx", {27'd0, bus.gnt_idx}, 32'd5);
    chk("g5_gnt", bus.gnt, 32'h0000_0020);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_gnt", bus.gnt, 32'h0000_0000);
    chk("midrst_valid", {31'd0, bus.gnt_valid}, 32'd0);
    chk("midrst_idx", {27'd0, bus.gnt_idx}, 32'd0);
    step();
    chk("regrant5_idx", {27'd0, bus.gnt_idx}, 32'd5);
    chk("regrant5_valid", {31'd0, bus.gnt_valid}, 32'd1);

    // owner 3 re-wins alone, loses to 4 when 4 also requests
    bus.req  = 32'h0000_0008;
    bus.done = 1'b1;
    step();
    chk("g3_idx", {27'd0, bus.gnt_idx}, 32'd3);
    step();
    chk("g3_again_idx", {27'd0, bus.gnt_idx}, 32'd3);
    chk("g3_again_valid", {31'd0, bus.gnt_valid}, 32'd1);
    bus.req = 32'h0000_0018;
    step();
    chk("g4_idx", {27'd0, bus.gnt_idx}, 32'd4);
    chk("g4_gnt", bus.gnt, 32'h0000_0010);

    // grant 7 and never release
    bus.req = 32'h0000_0180;
    step();
    bus.done = 1'b0;
    chk("g7_idx", {27'd0, bus.gnt_idx}, 32'd7);
    chk("g7_timeout", {31'd0, bus.timeout}, 32'd0);
`ifdef ARB_TIMEOUT_EN
    repeat (15) step();
    chk("to_pre_idx", {27'd0, bus.gnt_idx}, 32'd7);
    chk("to_pre_timeout", {31'd0, bus.timeout}, 32'd0);
    step();
    chk("to_pulse", {31'd0, bus.timeout}, 32'd1);
    chk("to_new_idx", {27'd0, bus.gnt_idx}, 32'd8);
    chk("to_new_valid", {31'd0, bus.gnt_valid}, 32'd1);
    step();
    chk("to_one_cycle", {31'd0, bus.timeout}, 32'd0);
    chk("to_hold8", {27'd0, bus.gnt_idx}, 32'd8);
`else
    seen_timeout = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      seen_timeout = seen_timeout | bus.timeout;
    end
    chk("no_to_idx", {27'd0, bus.gnt_idx}, 32'd7);
    chk("no_to_valid", {31'd0, bus.gnt_valid}, 32'd1);
    chk("no_to_timeout", {31'd0, seen_timeout}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_rr_arbiter.md
Name: decode_rr_arbiter

Overview:
- 32-way round-robin arbiter sharing one resource slot among 32 requesters.
- Selects a winner, registers its 5-bit index, and drives the one-hot grant as the 5-to-32 decode of that index, gated by valid.
- Owner holds the grant until it pulses done.
- Sits in front of any shared port whose select lines the team's 5-to-32 decoder drives: register-file write port, bus slave select, and similar.

Parameters:
- N, 32, number of requesters; fixed at 2^IDX_W.
- IDX_W, 5, index width.
- MAX_HOLD, 16, maximum grant tenure in cycles. Used only with ARB_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- done  input  1  current owner releases; ignored when gnt_valid=0.
- gnt  output  N  one-hot grant; all zero when gnt_valid=0.
- gnt_idx  output  IDX_W  index of current owner; holds last value when gnt_valid=0.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst high at an edge): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
  - Reset takes effect at that edge even mid-grant; there is no release handshake.
- Internal ptr (IDX_W bits) is the highest-priority index.
- Priority search scans ptr, ptr+1, ... mod N; the first set req bit wins.
- All outputs are registered. No combinational path from req or done to any output.
- State IDLE:
  - If |req at an edge: gnt_idx<=winner, gnt_valid<=1, state<=GRANT. Latency is one edge from req to gnt.
  - Otherwise outputs hold.
- State GRANT:
  - Owner keeps the grant while done=0, regardless of its req bit. Dropping req without done does not release.
  - req changes from other requesters have no effect until release.
- Release (done=1 in GRANT):
  - ptr<=(gnt_idx+1) mod N at that edge.
  - A new priority search runs at the same edge, starting from gnt_idx+1 mod N, over the current req.
  - If it finds a winner: back-to-back grant with no gap cycle. gnt_idx<=new winner, gnt_valid stays 1, state stays GRANT. The old owner can win again only if no other req bit is set.
  - If req is all zero: gnt_valid<=0, gnt<=0, state<=IDLE.
- Wrap-around: owner 31 releases → ptr=0.
- Simultaneous done and new req from the owner: treated as release. The owner competes at lowest priority.
- gnt = decode(gnt_idx) & {N{gnt_valid}}. Exactly zero or one bit is set at all times.
- IDLE ignores done.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit hold_cnt clears on every new grant, including back-to-back grants, and increments each GRANT cycle with done=0.
  - When hold_cnt==MAX_HOLD-1 and done=0, the next edge performs a forced release, identical to done=1 (ptr advance, rearbitration).
  - timeout=1 for exactly that one cycle after the edge.
  - done=1 in the same cycle as the limit is a normal release, with timeout=0.
- Undefined: no counter; timeout tied 0; the owner may hold indefinitely.

Test Plan:
- Reset, then req=0x0000_0001 for one cycle → next edge gnt=0x0000_0001, gnt_idx=0, gnt_valid=1. Drop req without done → grant stays for 10+ cycles.
- req=0xFFFF_FFFF constant, done pulsed every cycle → gnt_idx sequence 0,1,2,...,31,0 with no gap cycles and gnt_valid continuously 1.
- req=0x8000_0001: grant 0, done → grant 31, done → wraps to grant 0. Then req=0, done → gnt_valid=0 and gnt=0 the next cycle.
- While idx 5 is granted, assert rst for one edge → gnt=0, gnt_valid=0, gnt_idx=0. With req=0x20 held, re-grant of idx 5 occurs one edge after rst deasserts.
- Owner 3 releases with req=0x0000_0008 (only itself) → re-granted to 3 back-to-back. With req=0x0000_0018 → granted to 4.
- ARB_TIMEOUT_EN, MAX_HOLD=16: grant idx 7, done never asserted, req=0x180 → after 16 GRANT cycles timeout pulses once, gnt_idx=8. Without the macro, idx 7 is still held after 100 cycles and timeout stays 0.
